// File: rtl/binary_ctr.sv
// rtl/binary_ctr.sv - parameterised synchronous up/down binary counter
module binary_ctr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;

  // next count: unsigned WIDTH-bit add/subtract wraps modulo 2^WIDTH in both directions
  always_comb begin
    count_next = count;
    if (mode) begin
      count_next = count + WIDTH'(1);
    end else begin
      count_next = count - WIDTH'(1);
    end
  end

  // state register; reset wins over counting and is only seen at the clock edge
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  assign q = count;

endmodule

// File: tb/tb_binary_ctr.sv
// tb/tb_binary_ctr.sv - scoreboard bench for binary_ctr at widths 4, 1 and 8
module tb_binary_ctr;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       r4 = 1'b1, m4 = 1'b1;
  logic [3:0] q4;
  logic       r1 = 1'b1, m1 = 1'b1;
  logic [0:0] q1;
  logic       r8 = 1'b1, m8 = 1'b1;
  logic [7:0] q8;

  binary_ctr #(.WIDTH(4)) u_ctr4 (.clk(clk), .reset(r4), .mode(m4), .q(q4));
  binary_ctr #(.WIDTH(1)) u_ctr1 (.clk(clk), .reset(r1), .mode(m1), .q(q1));
  binary_ctr #(.WIDTH(8)) u_ctr8 (.clk(clk), .reset(r8), .mode(m8), .q(q8));

  int errors = 0;
  int checks = 0;

  logic [3:0] sb4[$];
  logic [0:0] sb1[$];
  logic [7:0] sb8[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // stimulus steps: drive at the falling edge, queue the value expected after the next rising edge
  task automatic s4(input logic r, input logic m, input logic [3:0] e);
    @(negedge clk);
    r4 = r;
    m4 = m;
    sb4.push_back(e);
  endtask

  task automatic s1(input logic r, input logic m, input logic [0:0] e);
    @(negedge clk);
    r1 = r;
    m1 = m;
    sb1.push_back(e);
  endtask

  task automatic s8(input logic r, input logic m, input logic [7:0] e);
    @(negedge clk);
    r8 = r;
    m8 = m;
    sb8.push_back(e);
  endtask

  // monitor: q is updated every rising edge, so every edge with a queued entry is compared
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb4.size() > 0) chk("q_w4", 32'(q4), 32'(sb4.pop_front()));
      if (sb1.size() > 0) chk("q_w1", 32'(q1), 32'(sb1.pop_front()));
      if (sb8.size() > 0) chk("q_w8", 32'(q8), 32'(sb8.pop_front()));
    end
  end

  initial begin
    // reset then count up through the wrap: 1..15, 0, 1
    s4(1'b1, 1'b1, 4'd0);
    for (int i = 1; i <= 17; i++) s4(1'b0, 1'b1, 4'(i));

    // up to 15, then down through zero: 14..0, 15, 14
    s4(1'b1, 1'b1, 4'd0);
    for (int i = 1; i <= 15; i++) s4(1'b0, 1'b1, 4'(i));
    for (int i = 14; i >= 0; i--) s4(1'b0, 1'b0, 4'(i));
    s4(1'b0, 1'b0, 4'd15);
    s4(1'b0, 1'b0, 4'd14);

    // down from reset: 15, 14, 13
    s4(1'b1, 1'b0, 4'd0);
    s4(1'b0, 1'b0, 4'd15);
    s4(1'b0, 1'b0, 4'd14);
    s4(1'b0, 1'b0, 4'd13);

    // reset asserted between edges at q=9 must not act before the edge
    s4(1'b1, 1'b1, 4'd0);
    for (int i = 1; i <= 9; i++) s4(1'b0, 1'b1, 4'(i));
    s4(1'b1, 1'b1, 4'd0);
    #1;
    chk("sync_reset_hold", 32'(q4), 32'd9);
    s4(1'b1, 1'b1, 4'd0);
    s4(1'b1, 1'b1, 4'd0);
    s4(1'b0, 1'b1, 4'd1);

    // direction toggle every edge from 5: 6, 5, 6, 5
    s4(1'b1, 1'b1, 4'd0);
    for (int i = 1; i <= 5; i++) s4(1'b0, 1'b1, 4'(i));
    s4(1'b0, 1'b1, 4'd6);
    s4(1'b0, 1'b0, 4'd5);
    s4(1'b0, 1'b1, 4'd6);
    s4(1'b0, 1'b0, 4'd5);

    // reset together with a mode change: q=0, then the new mode (down) applies
    s4(1'b1, 1'b0, 4'd0);
    s4(1'b0, 1'b0, 4'd15);
    s4(1'b1, 1'b1, 4'd0);

    // width 1: toggles in either direction
    s1(1'b1, 1'b1, 1'b0);
    s1(1'b0, 1'b1, 1'b1);
    s1(1'b0, 1'b1, 1'b0);
    s1(1'b0, 1'b1, 1'b1);
    s1(1'b0, 1'b1, 1'b0);
    s1(1'b0, 1'b0, 1'b1);
    s1(1'b1, 1'b1, 1'b0);

    // width 8: 0 down to 255, 255 up to 0, and back
    s8(1'b1, 1'b0, 8'd0);
    s8(1'b0, 1'b0, 8'd255);
    s8(1'b0, 1'b1, 8'd0);
    s8(1'b0, 1'b0, 8'd255);
    s8(1'b0, 1'b0, 8'd254);
    s8(1'b1, 1'b1, 8'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb4.size() + sb1.size() + sb8.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/binary_ctr.md
Name:
binary_ctr

Overview:
- Parameterised synchronous up/down binary counter.
- A single `mode` input selects the count direction.
- The output `q` changes on every rising clock edge and wraps modulo 2^WIDTH in both directions.
- General-purpose leaf block for sequencing, pointer generation and timebase logic; a single clock domain with no handshakes.

Parameters:
- WIDTH, 4, counter width in bits (legal: WIDTH >= 1); `q` spans 0 .. 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock; all state updates occur on this edge.
- reset  input  1  synchronous, active-high reset; sampled only at the rising edge of clk.
- mode  input  1  direction select: 1 = count up, 0 = count down; sampled at the rising edge of clk.
- q  output  WIDTH  current count, driven directly from a register (no combinational path from inputs).

Behaviour:
- Single clock, one WIDTH-bit state register; `q` equals that register.
- Reset:
  - reset=1 at a rising edge -> q becomes 0 at that edge, regardless of mode.
  - Reset has priority over counting.
  - Reset is synchronous: asserting it between edges has no effect until the next rising edge.
  - Holding reset high keeps q at 0 on every edge.
- Count up (reset=0, mode=1):
  - q <= q + 1 each rising edge.
  - At q = 2^WIDTH-1 the next value is 0 (wrap, no carry-out, no saturation).
- Count down (reset=0, mode=0):
  - q <= q - 1 each rising edge.
  - At q = 0 the next value is 2^WIDTH-1 (wrap).
- Latency:
  - First count edge after reset deassertion: q goes 0 -> 1 (up) or 0 -> 2^WIDTH-1 (down).
  - A mode change takes effect at the first rising edge at which the new value is sampled; the counter continues from its current value with no skipped or repeated states.
- Arithmetic: modulo 2^WIDTH, unsigned; no enable, no load, no terminal-count output.
- Power-up before the first reset: q is unspecified (X in simulation); a reset is required before q is considered valid.
- Mid-operation reset: q returns to 0 on the reset edge from any value and in either mode, then resumes counting in the sampled direction on the first edge with reset=0.
- Simultaneous reset=1 and a mode change at the same edge: q = 0; the new mode governs the following edge.

Test Plan:
- Reset then count up (WIDTH=4, 20 ns clock): reset=1, mode=1 for 1 edge -> q=0; release reset -> successive edges give q=1,2,…,15,0,1 (wrap after 16 edges).
- Count up then switch direction: after 15 up-edges q=15; set mode=0 -> next edges give q=14,13,…,0,15,14 (down-wrap at 0 -> 15).
- Down from reset: reset=1 then reset=0 with mode=0 -> q=0 then 15,14,13 on successive edges.
- Synchronous reset mid-count: at q=9 counting up, assert reset between edges -> q holds 9 until the next edge, then becomes 0; hold reset 3 edges -> q stays 0; release -> q=1.
- Direction toggle every edge: from q=5, alternate mode 1,0,1,0 -> q=6,5,6,5 (no skipped values).
- Width scaling: WIDTH=1 up-count -> q toggles 0,1,0,1; WIDTH=8 up-count from 255 -> next q=0; down-count from 0 -> next q=255.
